slave_fsm_arbiter: RTL



---
 rtl/fsm_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/slave_fsm_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared state encoding and timing defaults for the master/slave sequencing FSMs.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10,
    ERROR = 2'b11
  } fsm_state_t;

  localparam int unsigned TIMEOUT_PERIOD_DEF = 32'd50_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: combinational search from the pointer,
// pointer advanced past the winner when the grant is accepted.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_nxt;

  assign any = |req;

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    int   idx;
    int   nxt;
    logic found;
    gnt     = '0;
    ptr_nxt = ptr_q;
    found   = 1'b0;
    idx     = 0;
    nxt     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      nxt = (idx + 1) % NUM_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        found                 = 1'b1;
        gnt[idx[PTR_W-1:0]]   = 1'b1;
        ptr_nxt               = nxt[PTR_W-1:0];
      end
    end
  end

  // Winner moves to lowest priority once its grant is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else if (accept && any)
      ptr_q <= ptr_nxt;
  end

endmodule

// File: rtl/slave_fsm_arbiter.sv
// Shares one slave_fsm between NUM_REQ requesters: round-robin grant,
// start/done handshake with the slave, and timeout-driven abort.
//
// state | meaning
// IDLE  | no job; arbitrate over req, done pulse may be presented here
// START | slv_start pulsed, counter cleared
// WAIT  | slave working; watch for done or counter terminal count
// ERROR | timeout: slv_abort and req_err high, back to IDLE next
module slave_fsm_arbiter
  import fsm_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_PERIOD = TIMEOUT_PERIOD_DEF,
  parameter int          CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] req_done,
  output logic [NUM_REQ-1:0] req_err,
  output logic               slv_start,
  output logic               slv_abort,
  input  logic               slv_busy,
  input  logic               slv_done,
  output logic [1:0]         state,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_PERIOD - 1);

  fsm_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic [NUM_REQ-1:0] req_err_q, req_err_d;
  logic               slv_start_q, slv_start_d;
  logic               slv_abort_q, slv_abort_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .gnt    (arb_gnt),
    .any    (arb_any)
  );

  // Next state and next registered outputs; pulses default low.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    req_done_d  = '0;
    req_err_d   = '0;
    slv_start_d = 1'b0;
    slv_abort_d = 1'b0;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (arb_any) begin
          accept      = 1'b1;
          state_d     = START;
          gnt_d       = arb_gnt;
          slv_start_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (!slv_busy && slv_done) begin
          state_d    = IDLE;
          gnt_d      = '0;
          req_done_d = gnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ERROR;
          slv_abort_d = 1'b1;
          req_err_d   = gnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and all outputs registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      req_done_q  <= '0;
      req_err_q   <= '0;
      slv_start_q <= 1'b0;
      slv_abort_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      req_done_q  <= req_done_d;
      req_err_q   <= req_err_d;
      slv_start_q <= slv_start_d;
      slv_abort_q <= slv_abort_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign state     = state_q;
  assign gnt       = gnt_q;
  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign slv_start = slv_start_q;
  assign slv_abort = slv_abort_q;
  assign busy      = busy_q;

endmodule
